// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: loads a parallel pattern and shifts it out LSB first,
// with repeat passes and a trailing idle gap. Define SERIAL_PATTERN_TX_PARITY_EN for a per-pass parity bit.
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4,
    parameter int GAP   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic [REP_W-1:0] load_repeat,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : '0;
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_shift;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_len_last;
    logic [REP_W-1:0] r_pass;
    logic [GAP_W-1:0] r_gap;
    logic             r_out;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic [LEN_W-1:0] w_len_eff;
    logic [WIDTH-1:0] w_load_pattern;
    logic             w_accept;
    logic             w_last_data;
    logic             w_pass_end;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    logic r_par_phase;
    logic w_parity;

    function automatic logic [WIDTH-1:0] len_mask(input logic [LEN_W-1:0] len);
        len_mask = ~({WIDTH{1'b1}} << len);
    endfunction

    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        even_parity = ^d;
    endfunction

    // Stored pattern is pre-masked to L bits, so its reduction XOR is the pass parity
    assign w_parity       = even_parity(r_data);
    assign w_load_pattern = load_data & len_mask(w_len_eff);
    assign w_pass_end     = r_par_phase;
`else
    assign w_load_pattern = load_data;
    assign w_pass_end     = w_last_data;
`endif

    assign load_ready  = (r_state == ST_IDLE) && !reset;
    assign w_accept    = load_valid && load_ready;
    assign w_last_data = (r_cnt == r_len_last);
    assign out         = r_out;
    assign out_valid   = r_valid;
    assign busy        = r_busy;
    assign done        = r_done;

    // Effective pass length: zero or oversize requests fall back to the full width
    always_comb begin
        w_len_eff = load_len;
        if ((load_len == {LEN_W{1'b0}}) || (load_len > LEN_MAX)) begin
            w_len_eff = LEN_MAX;
        end else begin
            w_len_eff = load_len;
        end
    end

    // Transmit FSM with registered serial outputs and completion pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_data     <= '0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_len_last <= '0;
            r_pass     <= '0;
            r_gap      <= '0;
            r_out      <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            r_par_phase <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_state    <= ST_SHIFT;
                        r_data     <= w_load_pattern;
                        r_shift    <= {1'b0, w_load_pattern[WIDTH-1:1]};
                        r_out      <= w_load_pattern[0];
                        r_valid    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_cnt      <= '0;
                        r_len_last <= w_len_eff - LEN_W'(1);
                        r_pass     <= load_repeat;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                        r_par_phase <= 1'b0;
`endif
                    end else begin
                        r_out   <= 1'b0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    r_done <= 1'b0;
                    if (w_pass_end) begin
                        if (r_pass != {REP_W{1'b0}}) begin
                            // Next pass starts on the very next cycle, no idle bubble
                            r_pass  <= r_pass - REP_W'(1);
                            r_cnt   <= '0;
                            r_out   <= r_data[0];
                            r_shift <= {1'b0, r_data[WIDTH-1:1]};
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                            r_par_phase <= 1'b0;
`endif
                        end else if (GAP > 0) begin
                            r_state <= ST_GAP;
                            r_gap   <= GAP_LAST;
                            r_out   <= 1'b0;
                            r_valid <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_out   <= 1'b0;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                        if (w_last_data) begin
                            r_out       <= w_parity;
                            r_par_phase <= 1'b1;
                        end else begin
                            r_out   <= r_shift[0];
                            r_shift <= {1'b0, r_shift[WIDTH-1:1]};
                            r_cnt   <= r_cnt + LEN_W'(1);
                        end
`else
                        r_out   <= r_shift[0];
                        r_shift <= {1'b0, r_shift[WIDTH-1:1]};
                        r_cnt   <= r_cnt + LEN_W'(1);
`endif
                    end
                end
                ST_GAP: begin
                    r_out   <= 1'b0;
                    r_valid <= 1'b0;
                    if (r_gap == {GAP_W{1'b0}}) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_gap  <= r_gap - GAP_W'(1);
                        r_done <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_out   <= 1'b0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Serial pattern transmitter: the driving end of the single-bit `in` line consumed by the team's serial sequence-detector FSMs.
- Accepts a parallel bit pattern through a valid/ready load port and shifts it out one bit per clock, LSB first.
- Supports a programmable pattern length, a repeat count and a fixed idle gap after the last pass.
- Used as the stimulus source and link driver for the detector blocks.

Parameters:
WIDTH, 8, maximum pattern length in bits (2..32)
LEN_W, 4, width of load_len; must hold the value WIDTH
REP_W, 4, width of load_repeat
GAP, 1, idle cycles (out=0, out_valid=0) after the final pass; 0 allowed

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
load_valid  input  1  load request
load_ready  output  1  block can accept a load
load_data  input  WIDTH  pattern; bit 0 is sent first
load_len  input  LEN_W  number of bits per pass; 0 or values above WIDTH mean WIDTH
load_repeat  input  REP_W  additional passes; total passes = load_repeat+1
out  output  1  serial bit to the detector `in`
out_valid  output  1  out carries a pattern bit
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values, sampled at a clock edge with reset=1: state=IDLE, out=0, out_valid=0, busy=0, done=0, load_ready=0. load_ready becomes 1 in the first non-reset cycle. All registers are cleared.
- States: IDLE, SHIFT, GAP.
- All outputs are registered except load_ready, which equals (state==IDLE && !reset).
- IDLE: out=0, out_valid=0.
  - Accept at edge k when load_valid && load_ready. Capture data, effective length L and repeat count.
  - Go to SHIFT. Bit index=0, pass counter=load_repeat.
- SHIFT: out=pattern[index], out_valid=1, one bit per cycle. Bits occupy cycles k+1 .. k+L.
  - After bit L-1 with pass counter>0: decrement the counter, reset index to 0 and restart with no idle cycle, so passes are back-to-back.
  - After bit L-1 with pass counter==0: go to GAP if GAP>0, else IDLE.
- GAP: out=0, out_valid=0 for exactly GAP cycles, then IDLE.
- done: asserted for exactly one cycle, the first IDLE cycle after completion.
  - Cycle k + L*(load_repeat+1) + GAP + 1 without parity.
  - load_ready is also 1 in that cycle, so a new load can be accepted on the same edge (done-and-accept). The next pattern's bit 0 appears on the following cycle.
- load_valid is ignored while busy. The captured pattern cannot be changed mid-transmission.
- load_len of 1 is legal: one bit per pass.
- Reset mid-operation: transmission is aborted at the reset edge. Outputs return to reset values, and no done pulse is generated for the aborted pattern.
- Repeat counter wrap: load_repeat = 2^REP_W-1 gives 2^REP_W passes. The counter never underflows.

Optional Feature:
- Macro: SERIAL_PATTERN_TX_PARITY_EN.
- Defined:
  - After the L pattern bits of every pass, one extra cycle carries the even-parity bit (XOR of the L bits sent), with out_valid=1.
  - Effective pass length is L+1, and all timing above uses L+1.
  - The parity bit is recomputed per pass; it is identical each pass.
- Undefined: no parity cycle and no parity logic is synthesized.

Test Plan:
1. Reset held 3 cycles with load_valid=1 -> out=0, out_valid=0, busy=0, done=0 throughout; load_ready=1 in the first cycle after reset drops; no load is accepted during reset.
2. load_data=8'b0000_1001, load_len=4, repeat=0, GAP=1, accepted at edge k -> out=1,0,0,1 at cycles k+1..k+4 with out_valid=1; out=0, out_valid=0 at k+5; done=1 only at k+6.
3. load_data=8'b0000_0110, load_len=3, repeat=2 -> out=0,1,1,0,1,1,0,1,1 contiguous; busy high for 10 cycles including the gap; exactly one done pulse.
4. load_len=0, load_data=8'hA5 -> 8 bits 1,0,1,0,0,1,0,1; a second load held valid during transmission is accepted only at the done cycle, and its first bit follows immediately after.
5. Assert reset at the 3rd bit of a 8-bit pattern -> out=0, busy=0 on the next cycle; no done pulse; a fresh load afterwards transmits correctly.
6. With SERIAL_PATTERN_TX_PARITY_EN: data=4'b1011, len=4, repeat=1 -> out=1,1,0,1,1,1,1,0,1,1 with out_valid=1 for all 10 cycles; done at k+12 (GAP=1).
